// File: rtl/alu_cmd_sequencer.sv
// Command FIFO and pin sequencer for tiny_4bit_alu: holds each {op,A,B} on the ALU pins
// for SETTLE cycles, samples uo_out and returns it in order on a valid/ready port.
module alu_cmd_sequencer #(
   parameter int DEPTH  = 4,
   parameter int SETTLE = 2
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   cmd_valid,
   output logic                   cmd_ready,
   input  logic [3:0]             cmd_op,
   input  logic [3:0]             cmd_a,
   input  logic [3:0]             cmd_b,
   output logic [7:0]             alu_ui,
   output logic [7:0]             alu_uio,
   input  logic [7:0]             alu_uo,
   output logic                   rsp_valid,
   input  logic                   rsp_ready,
   output logic [3:0]             rsp_result,
   output logic [3:0]             rsp_flags,
   output logic [3:0]             rsp_op,
   output logic [$clog2(DEPTH):0] level,
   output logic                   busy
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;
   localparam int CW = $clog2(SETTLE + 1);

   // PASS_B with B=0: harmless to the ALU register file
   localparam logic [7:0] IDLE_UI  = 8'h00;
   localparam logic [7:0] IDLE_UIO = 8'h07;

   typedef enum logic [1:0] {IDLE, DRIVE, RESP} state_t;

   typedef struct packed {
      logic [3:0] op;
      logic [3:0] b;
      logic [3:0] a;
   } cmd_t;

   state_t        state;
   cmd_t          mem [DEPTH];
   cmd_t          head;
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [CW-1:0] cnt;
   logic          push;
   logic          pop;

   assign cmd_ready = (level < LW'(DEPTH));
   assign push      = cmd_valid && cmd_ready;
   assign pop       = (level != '0) && ((state == IDLE) || ((state == RESP) && rsp_ready));
   assign head      = mem[rd_ptr];
   assign busy      = (state != IDLE) || (level != '0);

   // NOTE: the storage array is deliberately not reset; level guarantees no stale entry is read.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= '{op: cmd_op, b: cmd_b, a: cmd_a};
   end

   // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         level <= level + LW'(push) - LW'(pop);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         cnt        <= '0;
         alu_ui     <= IDLE_UI;
         alu_uio    <= IDLE_UIO;
         rsp_valid  <= 1'b0;
         rsp_result <= '0;
         rsp_flags  <= '0;
         rsp_op     <= '0;
      end else begin
         case (state)
            DRIVE: begin
               if (cnt == CW'(1)) begin
                  rsp_result <= alu_uo[3:0];
                  rsp_flags  <= alu_uo[7:4];
                  rsp_valid  <= 1'b1;
                  alu_ui     <= IDLE_UI;
                  alu_uio    <= IDLE_UIO;
                  state      <= RESP;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            RESP: begin
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase

         // NOTE: placed after the case so a back-to-back pop in RESP overrides the IDLE fallback.
         if (pop) begin
            alu_ui  <= {head.b, head.a};
            alu_uio <= {4'b0000, head.op};
            rsp_op  <= head.op;
            cnt     <= CW'(SETTLE);
            state   <= DRIVE;
         end
      end
   end

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Bench for alu_cmd_sequencer with a behavioural tiny_4bit_alu on its pins, directed
// vectors for the corner cases and a randomized run against an in-order reference model.
module tb_alu_cmd_sequencer;

   localparam int DEPTH  = 4;
   localparam int SETTLE = 2;

   localparam logic [3:0] OP_ADD    = 4'b0000;
   localparam logic [3:0] OP_PASS_B = 4'b0111;
   localparam logic [3:0] OP_WR     = 4'b1000;
   localparam logic [3:0] OP_RD     = 4'b1001;
   localparam logic [3:0] OP_ADDR   = 4'b1010;
   localparam logic [3:0] OP_SUBR   = 4'b1011;

   logic                   clk = 1'b0;
   logic                   rst;
   logic                   cmd_valid;
   logic                   cmd_ready;
   logic [3:0]             cmd_op, cmd_a, cmd_b;
   logic [7:0]             alu_ui, alu_uio, alu_uo;
   logic                   rsp_valid, rsp_ready;
   logic [3:0]             rsp_result, rsp_flags, rsp_op;
   logic [$clog2(DEPTH):0] level;
   logic                   busy;

   typedef struct {
      logic [3:0] op;
      logic [3:0] res;
      logic [3:0] flags;
      int         t;
   } rsp_t;

   typedef struct {
      logic [3:0] op;
      logic [3:0] a;
      logic [3:0] b;
      logic [3:0] res;
      bit         chk;
   } vec_t;

   int   checks   = 0;
   int   failures = 0;
   int   cyc      = 0;
   bit   sb_on    = 1'b0;
   rsp_t got_q[$];
   rsp_t exp_q[$];
   logic [3:0] alu_regs   [16] = '{default: 4'h0};
   logic [3:0] model_regs [16] = '{default: 4'h0};

   alu_cmd_sequencer #(.DEPTH(DEPTH), .SETTLE(SETTLE)) dut (
      .clk        (clk),
      .rst        (rst),
      .cmd_valid  (cmd_valid),
      .cmd_ready  (cmd_ready),
      .cmd_op     (cmd_op),
      .cmd_a      (cmd_a),
      .cmd_b      (cmd_b),
      .alu_ui     (alu_ui),
      .alu_uio    (alu_uio),
      .alu_uo     (alu_uo),
      .rsp_valid  (rsp_valid),
      .rsp_ready  (rsp_ready),
      .rsp_result (rsp_result),
      .rsp_flags  (rsp_flags),
      .rsp_op     (rsp_op),
      .level      (level),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   // ALU behaviour: {Z,N,V,C,result}; SUB_REG computes A - reg[B] with C as borrow.
   function automatic logic [7:0] alu_eval(input logic [3:0] op, a, b, rb);
      logic [4:0] s;
      logic [3:0] r;
      logic       c, v;
      r = 4'h0; c = 1'b0; v = 1'b0;
      case (op)
         OP_ADD, OP_ADDR: begin
            s = {1'b0, a} + {1'b0, (op == OP_ADD) ? b : rb};
            r = s[3:0]; c = s[4];
            v = (a[3] == ((op == OP_ADD) ? b[3] : rb[3])) && (r[3] != a[3]);
         end
         OP_SUBR: begin
            s = {1'b0, a} - {1'b0, rb};
            r = s[3:0]; c = s[4];
            v = (a[3] != rb[3]) && (r[3] != a[3]);
         end
         OP_PASS_B: r = b;
         OP_WR:     r = a;
         OP_RD:     r = rb;
         default:   r = 4'h0;
      endcase
      return {(r == 4'h0), r[3], v, c, r};
   endfunction

   always_comb alu_uo = alu_eval(alu_uio[3:0], alu_ui[3:0], alu_ui[7:4], alu_regs[alu_ui[7:4]]);

   always @(posedge clk) begin
      if (alu_uio[3:0] == OP_WR) alu_regs[alu_ui[7:4]] <= alu_ui[3:0];
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   // One clock: log the response handshake and any accepted command, then advance.
   task automatic cycle();
      rsp_t       r;
      logic [7:0] v;
      if (rsp_valid && rsp_ready) begin
         r.op = rsp_op; r.res = rsp_result; r.flags = rsp_flags; r.t = cyc;
         got_q.push_back(r);
      end
      if (sb_on && cmd_valid && cmd_ready) begin
         v = alu_eval(cmd_op, cmd_a, cmd_b, model_regs[cmd_b]);
         r.op = cmd_op; r.res = v[3:0]; r.flags = v[7:4]; r.t = 0;
         exp_q.push_back(r);
         if (cmd_op == OP_WR) model_regs[cmd_b] = cmd_a;
      end
      step();
   endtask

   task automatic send(input logic [3:0] op, a, b);
      bit done = 1'b0;
      int n    = 0;
      cmd_valid = 1'b1; cmd_op = op; cmd_a = a; cmd_b = b;
      while (!done && n < 50) begin
         done = cmd_ready;
         cycle();
         n++;
      end
      cmd_valid = 1'b0;
      if (!done) check("send_timeout", 32'd0, 32'd1);
   endtask

   task automatic wait_rsp(input string name, input int n, input int budget);
      int k = 0;
      while (got_q.size() < n && k < budget) begin
         cycle();
         k++;
      end
      check(name, got_q.size(), n);
   endtask

   task automatic wait_idle();
      int k = 0;
      while (busy && k < 100) begin
         cycle();
         k++;
      end
      if (busy) check("idle_timeout", 32'd1, 32'd0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      vec_t       vecs [5];
      logic [3:0] ops  [6];
      logic [3:0] s_res, s_flags, s_op;
      bit         stable;
      int         lat, accepted, k;

      rst = 1'b1; cmd_valid = 1'b0; rsp_ready = 1'b0;
      cmd_op = '0; cmd_a = '0; cmd_b = '0;

      vecs[0] = '{op: OP_WR,     a: 4'd7, b: 4'd3, res: 4'd7,  chk: 1'b0};
      vecs[1] = '{op: OP_RD,     a: 4'd0, b: 4'd3, res: 4'd7,  chk: 1'b1};
      vecs[2] = '{op: OP_ADDR,   a: 4'd2, b: 4'd3, res: 4'd9,  chk: 1'b1};
      vecs[3] = '{op: OP_SUBR,   a: 4'd2, b: 4'd3, res: 4'd11, chk: 1'b1};
      vecs[4] = '{op: OP_PASS_B, a: 4'd1, b: 4'd9, res: 4'd9,  chk: 1'b1};
      ops = '{OP_ADD, OP_PASS_B, OP_WR, OP_RD, OP_ADDR, OP_SUBR};

      // Reset values
      repeat (2) step();
      check("rst_cmd_ready", cmd_ready, 1);
      check("rst_rsp_valid", rsp_valid, 0);
      check("rst_level",     level, 0);
      check("rst_alu_ui",    alu_ui, 8'h00);
      check("rst_alu_uio",   alu_uio, 8'h07);
      check("rst_busy",      busy, 0);
      rst = 1'b0;
      step();

      // Single ADD: latency and result
      rsp_ready = 1'b1;
      got_q.delete();
      send(OP_ADD, 4'd3, 4'd5);
      lat = 0;
      while (!rsp_valid && lat < 20) begin
         cycle();
         lat++;
      end
      check("add_latency", lat, SETTLE + 1);
      check("add_result",  rsp_result, 4'b1000);
      check("add_flags",   rsp_flags, 4'b0110);
      check("add_op",      rsp_op, OP_ADD);
      cycle();
      check("add_rsp_cleared", rsp_valid, 0);
      check("add_rsp_count",   got_q.size(), 1);

      // Register-file sequence from the vector table
      wait_idle();
      got_q.delete();
      for (int i = 0; i < 5; i++) send(vecs[i].op, vecs[i].a, vecs[i].b);
      wait_rsp("seq_count", 5, 100);
      for (int i = 0; i < 5 && i < got_q.size(); i++) begin
         check($sformatf("seq_op_%0d", i), got_q[i].op, vecs[i].op);
         if (vecs[i].chk) check($sformatf("seq_res_%0d", i), got_q[i].res, vecs[i].res);
      end

      // Stalled consumer: fill the FIFO while one response is held
      wait_idle();
      got_q.delete();
      rsp_ready = 1'b0;
      accepted  = 0;
      for (int i = 0; i < 12; i++) begin
         cmd_valid = (accepted < DEPTH + 3);
         cmd_op = OP_PASS_B; cmd_a = 4'(accepted); cmd_b = 4'(accepted + 1);
         if (cmd_valid && cmd_ready) accepted++;
         cycle();
      end
      cmd_valid = 1'b0;
      check("full_accepted",  accepted, DEPTH + 1);
      check("full_level",     level, DEPTH);
      check("full_cmd_ready", cmd_ready, 0);
      check("full_rsp_valid", rsp_valid, 1);
      check("full_idle_uio",  alu_uio, 8'h07);
      s_res = rsp_result; s_flags = rsp_flags; s_op = rsp_op;
      stable = 1'b1;
      repeat (4) begin
         cycle();
         stable &= rsp_valid && (rsp_result == s_res) && (rsp_flags == s_flags) && (rsp_op == s_op);
      end
      check("stall_stable", stable, 1);
      check("stall_result", rsp_result, 4'd1);

      // Release: drain in order with SETTLE+1 spacing
      rsp_ready = 1'b1;
      cycle();
      check("drain_cmd_ready", cmd_ready, 1);
      wait_rsp("drain_count", DEPTH + 1, 100);
      for (int i = 0; i < DEPTH + 1 && i < got_q.size(); i++) begin
         check($sformatf("drain_res_%0d", i), got_q[i].res, 4'(i + 1));
         if (i > 0) check($sformatf("drain_gap_%0d", i), got_q[i].t - got_q[i-1].t, SETTLE + 1);
      end

      // Reset during DRIVE with two queued commands
      wait_idle();
      got_q.delete();
      send(OP_PASS_B, 4'd0, 4'd2);
      send(OP_PASS_B, 4'd0, 4'd3);
      send(OP_PASS_B, 4'd0, 4'd4);
      check("abort_pre_level", level, 2);
      check("abort_pre_drive", alu_uio, {4'b0000, OP_PASS_B});
      #2 rst = 1'b1;
      #1;
      check("abort_rsp_valid", rsp_valid, 0);
      check("abort_level",     level, 0);
      check("abort_alu_uio",   alu_uio, 8'h07);
      check("abort_alu_ui",    alu_ui, 8'h00);
      step();
      rst = 1'b0;
      repeat (8) cycle();
      check("abort_no_rsp", got_q.size(), 0);
      send(OP_PASS_B, 4'd0, 4'd9);
      wait_rsp("post_rst_count", 1, 30);
      if (got_q.size() > 0) check("post_rst_res", got_q[0].res, 4'd9);

      // Randomized traffic against the in-order model
      wait_idle();
      got_q.delete();
      exp_q.delete();
      model_regs = alu_regs;
      sb_on = 1'b1;
      for (int i = 0; i < 600; i++) begin
         cmd_valid = ($urandom_range(0, 2) != 0);
         cmd_op    = ops[$urandom_range(0, 5)];
         cmd_a     = 4'($urandom);
         cmd_b     = 4'($urandom);
         rsp_ready = ($urandom_range(0, 3) != 0);
         cycle();
      end
      cmd_valid = 1'b0;
      rsp_ready = 1'b1;
      k = 0;
      while ((busy || got_q.size() < exp_q.size()) && k < 200) begin
         cycle();
         k++;
      end
      sb_on = 1'b0;
      check("rand_count", got_q.size(), exp_q.size());
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
         check($sformatf("rand_op_%0d", i),    got_q[i].op,    exp_q[i].op);
         check($sformatf("rand_res_%0d", i),   got_q[i].res,   exp_q[i].res);
         check($sformatf("rand_flags_%0d", i), got_q[i].flags, exp_q[i].flags);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
